// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, BYPASS/IDCODE data registers,
// TDO steering and capture/shift/update strobes for the external data register.
package tap_pkg;
  typedef logic [3:0] tap_ctrl_fsm_t;

  // Classic 1149.1 state encoding
  localparam logic [3:0] EXIT2_DR         = 4'h0;
  localparam logic [3:0] EXIT1_DR         = 4'h1;
  localparam logic [3:0] SHIFT_DR         = 4'h2;
  localparam logic [3:0] PAUSE_DR         = 4'h3;
  localparam logic [3:0] SELECT_IR_SCAN   = 4'h4;
  localparam logic [3:0] UPDATE_DR        = 4'h5;
  localparam logic [3:0] CAPTURE_DR       = 4'h6;
  localparam logic [3:0] SELECT_DR_SCAN   = 4'h7;
  localparam logic [3:0] EXIT2_IR         = 4'h8;
  localparam logic [3:0] EXIT1_IR         = 4'h9;
  localparam logic [3:0] SHIFT_IR         = 4'hA;
  localparam logic [3:0] PAUSE_IR         = 4'hB;
  localparam logic [3:0] RUN_TEST_IDLE    = 4'hC;
  localparam logic [3:0] UPDATE_IR        = 4'hD;
  localparam logic [3:0] CAPTURE_IR       = 4'hE;
  localparam logic [3:0] TEST_LOGIC_RESET = 4'hF;

  // Decoded instruction flags; neither set selects the external DR
  typedef struct packed {
    logic idcode;
    logic bypass;
  } ir_decoding_t;
endpackage

module tap_controller
  import tap_pkg::*;
#(
  parameter int unsigned          IDCODE_W     = 32,
  parameter logic [IDCODE_W-1:0]  IDCODE_VALUE = IDCODE_W'(32'h1BEEF001)
) (
  input  logic          tck,
  input  logic          trst,
  input  logic          tms,
  input  logic          tdi,
  input  ir_decoding_t  ir_dec,
  input  logic          ir_tdo,
  input  logic          ext_dr_tdo,
  output tap_ctrl_fsm_t tap_state,
  output logic          tdo,
  output logic          tdo_en,
  output logic          ext_capture_dr,
  output logic          ext_shift_dr,
  output logic          ext_update_dr
);

  logic [3:0]          state;
  logic [3:0]          state_next;
  logic                bypass_ff;
  logic [IDCODE_W-1:0] idcode_sr;
  logic                sel_idcode;
  logic                sel_bypass;
  logic                sel_ext;

  assign tap_state  = state;
  assign sel_idcode = ir_dec.idcode;
  assign sel_bypass = ir_dec.bypass & ~ir_dec.idcode;
  assign sel_ext    = ~(ir_dec.idcode | ir_dec.bypass);

  always_ff @(posedge tck) begin
    if (trst) state <= TEST_LOGIC_RESET;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TEST_LOGIC_RESET: state_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_next = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_next = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_next = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_next = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_next = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_next = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_next = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_next = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_next = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

  // Internal DRs move only in CAPTURE_DR/SHIFT_DR of their own instruction
  always_ff @(posedge tck) begin
    if (trst) begin
      bypass_ff <= 1'b0;
      idcode_sr <= IDCODE_VALUE;
    end else if (state == CAPTURE_DR) begin
      if (sel_bypass) bypass_ff <= 1'b0;
      if (sel_idcode) idcode_sr <= IDCODE_VALUE;
    end else if (state == SHIFT_DR) begin
      if (sel_bypass) bypass_ff <= tdi;
      if (sel_idcode) idcode_sr <= {tdi, idcode_sr[IDCODE_W-1:1]};
    end
  end

  always_comb begin
    tdo            = 1'b0;
    tdo_en         = 1'b0;
    ext_capture_dr = 1'b0;
    ext_shift_dr   = 1'b0;
    ext_update_dr  = 1'b0;
    case (state)
      SHIFT_IR: begin
        tdo    = ir_tdo;
        tdo_en = 1'b1;
      end
      SHIFT_DR: begin
        tdo_en       = 1'b1;
        tdo          = sel_idcode ? idcode_sr[0] : (sel_bypass ? bypass_ff : ext_dr_tdo);
        ext_shift_dr = sel_ext;
      end
      CAPTURE_DR: ext_capture_dr = sel_ext;
      UPDATE_DR:  ext_update_dr  = sel_ext;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: named-state TAP model with queue-based DRs checked
// every cycle, plus directed scans with literal expectations.
module tb_tap_controller;
  import tap_pkg::*;

  localparam logic [31:0] IDC = 32'h1BEEF001;

  logic          tck = 1'b0;
  logic          trst = 1'b1;
  logic          tms = 1'b1;
  logic          tdi = 1'b0;
  logic          ir_tdo = 1'b0;
  logic          ext_dr_tdo = 1'b0;
  ir_decoding_t  ir_dec;
  tap_ctrl_fsm_t tap_state;
  logic          tdo, tdo_en, ext_capture_dr, ext_shift_dr, ext_update_dr;

  tap_controller dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .ir_dec(ir_dec),
    .ir_tdo(ir_tdo), .ext_dr_tdo(ext_dr_tdo), .tap_state(tap_state),
    .tdo(tdo), .tdo_en(tdo_en), .ext_capture_dr(ext_capture_dr),
    .ext_shift_dr(ext_shift_dr), .ext_update_dr(ext_update_dr)
  );

  always #5 tck = ~tck;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                    SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} st_e;

  function automatic st_e m_next(st_e s, logic t);
    case (s)
      TLR:  return t ? TLR  : RTI;
      RTI:  return t ? SDR  : RTI;
      SDR:  return t ? SIR  : CDR;
      CDR:  return t ? E1DR : SHDR;
      SHDR: return t ? E1DR : SHDR;
      E1DR: return t ? UDR  : PDR;
      PDR:  return t ? E2DR : PDR;
      E2DR: return t ? UDR  : SHDR;
      UDR:  return t ? SDR  : RTI;
      SIR:  return t ? TLR  : CIR;
      CIR:  return t ? E1IR : SHIR;
      SHIR: return t ? E1IR : SHIR;
      E1IR: return t ? UIR  : PIR;
      PIR:  return t ? E2IR : PIR;
      E2IR: return t ? UIR  : SHIR;
      default: return t ? SDR : RTI;
    endcase
  endfunction

  function automatic logic [3:0] enc(st_e s);
    case (s)
      TLR:  return TEST_LOGIC_RESET;
      RTI:  return RUN_TEST_IDLE;
      SDR:  return SELECT_DR_SCAN;
      CDR:  return CAPTURE_DR;
      SHDR: return SHIFT_DR;
      E1DR: return EXIT1_DR;
      PDR:  return PAUSE_DR;
      E2DR: return EXIT2_DR;
      UDR:  return UPDATE_DR;
      SIR:  return SELECT_IR_SCAN;
      CIR:  return CAPTURE_IR;
      SHIR: return SHIFT_IR;
      E1IR: return EXIT1_IR;
      PIR:  return PAUSE_IR;
      E2IR: return EXIT2_IR;
      default: return UPDATE_IR;
    endcase
  endfunction

  st_e  ms = TLR;
  bit   m_valid = 1'b0;
  logic mq[$];
  logic mb = 1'b0;

  function automatic void load_id();
    logic [31:0] v;
    v = IDC;
    mq.delete();
    for (int i = 0; i < 32; i++) mq.push_back(v[i]);
  endfunction

  always @(posedge tck) begin
    if (trst) begin
      ms = TLR;
      mb = 1'b0;
      load_id();
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (ms == CDR) begin
        if (ir_dec.idcode) load_id();
        else if (ir_dec.bypass) mb = 1'b0;
      end else if (ms == SHDR) begin
        if (ir_dec.idcode) begin
          void'(mq.pop_front());
          mq.push_back(tdi);
        end else if (ir_dec.bypass) mb = tdi;
      end
      ms = m_next(ms, tms);
    end
  end

  // Compare all outputs against the model every cycle once reset has been seen
  always @(negedge tck) begin
    logic e_tdo, e_en, ext;
    if (m_valid) begin
      ext   = !ir_dec.idcode && !ir_dec.bypass;
      e_tdo = 1'b0;
      e_en  = 1'b0;
      if (ms == SHIR) begin
        e_tdo = ir_tdo;
        e_en  = 1'b1;
      end else if (ms == SHDR) begin
        e_en  = 1'b1;
        e_tdo = ir_dec.idcode ? mq[0] : (ir_dec.bypass ? mb : ext_dr_tdo);
      end
      check("tap_state", 32'(tap_state), 32'(enc(ms)));
      check("tdo", 32'(tdo), 32'(e_tdo));
      check("tdo_en", 32'(tdo_en), 32'(e_en));
      check("ext_capture_dr", 32'(ext_capture_dr), 32'(ext && ms == CDR));
      check("ext_shift_dr", 32'(ext_shift_dr), 32'(ext && ms == SHDR));
      check("ext_update_dr", 32'(ext_update_dr), 32'(ext && ms == UDR));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    ext_dr_tdo = 1'($urandom);
    ir_tdo = 1'($urandom);
    @(posedge tck);
    #1;
  endtask

  task automatic ext_scan(output int c, output int s, output int u);
    logic [12:0] seq;
    seq = 13'b1_000000000_110;
    c = 0; s = 0; u = 0;
    for (int i = 12; i >= 0; i--) begin
      step(seq[i], 1'b0);
      c += int'(ext_capture_dr);
      s += int'(ext_shift_dr);
      u += int'(ext_update_dr);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  tdi_seq;
    logic [3:0]  exp_path [5];
    int c, s, u;

    ir_dec = '{idcode: 1'b1, bypass: 1'b0};
    repeat (2) @(posedge tck);
    #1;
    trst = 1'b0;
    check("reset_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
    check("reset_tdo_en", 32'(tdo_en), 32'd0);

    // IDCODE readout, then flushed zeros
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    check("reach_shift_dr", 32'(tap_state), 32'(SHIFT_DR));
    rd = '0;
    for (int i = 0; i < 32; i++) begin rd[i] = tdo; step(0, 0); end
    check("idcode_read", rd, 32'h1BEEF001);
    rd = '1;
    for (int i = 0; i < 32; i++) begin rd[i] = tdo; step(0, 0); end
    check("idcode_flushed", rd, 32'h0);
    step(1, 0); step(1, 0); step(0, 0);

    // BYPASS: one-cycle delay, first bit is the captured 0
    ir_dec = '{idcode: 1'b0, bypass: 1'b1};
    step(1, 0); step(0, 0); step(0, 0);
    tdi_seq = 4'b1101;
    rd = '0;
    for (int i = 0; i < 4; i++) begin rd[i] = tdo; step(i == 3, tdi_seq[i]); end
    check("bypass_tdo", rd, 32'b1010);
    step(1, 0); step(0, 0);

    // External DR strobes, then none with IDCODE selected
    ir_dec = '{idcode: 1'b0, bypass: 1'b0};
    ext_scan(c, s, u);
    check("ext_capture_cnt", 32'(c), 32'd1);
    check("ext_shift_cnt", 32'(s), 32'd8);
    check("ext_update_cnt", 32'(u), 32'd1);
    ir_dec = '{idcode: 1'b1, bypass: 1'b0};
    ext_scan(c, s, u);
    check("ext_quiet_idcode", 32'(c + s + u), 32'd0);

    // Pause path: idcode_sr holds across EXIT1/PAUSE/EXIT2
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 0); step(0, 0); step(0, 0); step(1, 0);
    step(0, 0); step(0, 0); step(0, 0);
    check("in_pause_dr", 32'(tap_state), 32'(PAUSE_DR));
    step(1, 0); step(0, 0);
    check("resume_bit4", 32'(tdo), 32'd0);
    rd = '0;
    for (int i = 0; i < 12; i++) begin rd[i] = tdo; step(i == 11, 1'b0); end
    check("resume_bits_4_15", rd, 32'hF00);
    step(1, 0); step(0, 0);

    // IR shift: tdo follows ir_tdo
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      ir_tdo = i[0];
      #1;
      check("ir_tdo_follow", 32'(tdo), 32'(i[0]));
      check("ir_tdo_en", 32'(tdo_en), 32'd1);
      step(0, 0);
    end
    step(1, 0); step(0, 0);
    check("in_pause_ir", 32'(tap_state), 32'(PAUSE_IR));

    // Soft reset: five tms=1 edges from PAUSE_IR
    exp_path[0] = EXIT2_IR;
    exp_path[1] = UPDATE_IR;
    exp_path[2] = SELECT_DR_SCAN;
    exp_path[3] = SELECT_IR_SCAN;
    exp_path[4] = TEST_LOGIC_RESET;
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      check("soft_reset_path", 32'(tap_state), 32'(exp_path[i]));
    end

    // trst mid-shift restores IDCODE
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(0, 1);
    trst = 1'b1;
    step(0, 0);
    trst = 1'b0;
    check("trst_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
    check("trst_tdo_en", 32'(tdo_en), 32'd0);
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    rd = '0;
    for (int i = 0; i < 32; i++) begin rd[i] = tdo; step(i == 31, 1'b0); end
    check("idcode_after_trst", rd, 32'h1BEEF001);
    step(1, 0); step(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
